bcd_countdown_timer: RTL

Multi-digit BCD down-counter with load, start/pause control and a terminal-count pulse. It is the counting-down counterpart of the team's decade up-counter: each digit decrements 9→0 and issues a borrow to the next digit instead of a carry. It sits beside the up-counter in the timer/display datapath and drives the same BCD display path. A rate-divided `tick` enable paces it.

---
 rtl/timer_pkg.sv | 15 +
 rtl/bcd_down_digit.sv | 30 +++
 rtl/bcd_countdown_timer.sv | 110 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the FSM state enum and the decade limits used by every digit.
package timer_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One decade down-counter: 9..0 with wrap to 9.
// The borrow output is combinational so a chain of digits ripples in one cycle.
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_digit,
    input  logic             i_en,
    output logic [BCD_W-1:0] o_count,
    output logic             o_bo
);

    logic [BCD_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_digit;
        end else if (i_en) begin
            r_count <= (r_count == '0) ? BCD_MAX : r_count - 4'd1;
        end
    end

    assign o_count = r_count;
    assign o_bo    = i_en && (r_count == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with load, start/pause control and a
// one-cycle done pulse when the count reaches zero.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [4*DIGITS-1:0] i_load_val,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_tick,
    output logic [4*DIGITS-1:0] o_count,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_zero
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_done;
    logic                r_busy;
    logic                w_next_done;
    logic [4*DIGITS-1:0] w_count;
    logic [4*DIGITS-1:0] w_load_clamped;
    logic [DIGITS:0]     w_borrow;
    logic                w_tick_run;
    logic                w_count_is_one;

    // load and pause both outrank tick, so neither lets a decrement through
    assign w_tick_run     = i_tick && (r_state == ST_RUN) && !i_load && !i_pause;
    assign w_borrow[0]    = w_tick_run;
    assign w_count_is_one = (w_count == {{(4*DIGITS-1){1'b0}}, 1'b1});

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_load_clamped[4*gi +: 4] =
            (i_load_val[4*gi +: 4] > BCD_MAX) ? BCD_MAX : i_load_val[4*gi +: 4];

        bcd_down_digit u_digit (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_load       (i_load),
            .i_load_digit (w_load_clamped[4*gi +: 4]),
            .i_en         (w_borrow[gi]),
            .o_count      (w_count[4*gi +: 4]),
            .o_bo         (w_borrow[gi+1])
        );
    end

    always_comb begin
        w_next_state = r_state;
        w_next_done  = 1'b0;
        if (i_load) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (o_zero) begin
                            w_next_state = ST_DONE;
                            w_next_done  = 1'b1;
                        end else begin
                            w_next_state = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_pause) begin
                        w_next_state = ST_PAUSE;
                    // a top-digit borrow would mean underflow; stop there too
                    end else if (w_tick_run && (w_count_is_one || w_borrow[DIGITS])) begin
                        w_next_state = ST_DONE;
                        w_next_done  = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (i_start) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (i_start) begin
                        w_next_done = 1'b1;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_next_done;
            r_busy  <= (w_next_state == ST_RUN) || (w_next_state == ST_PAUSE);
        end
    end

    assign o_count = w_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_zero  = (w_count == '0);

endmodule
